// File: rtl/lut_breadboard_if.sv
// rtl/lut_breadboard_if.sv - programming bus and row stream bundle for lut_breadboard
interface lut_breadboard_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10,
  parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
  // truth-table programming bus
  logic                  prog_we;
  logic [SEL_W-1:0]      prog_sel;
  logic [(1<<N_IN)-1:0]  prog_tt;
  // evaluated row stream
  logic [N_OUT-1:0]      f;
  logic [N_IN-1:0]       out_idx;
  logic                  out_valid;
  logic                  out_ready;

  // host / bench side: programs tables, consumes rows
  modport master (
    output prog_we, prog_sel, prog_tt, out_ready,
    input  f, out_idx, out_valid
  );

  // breadboard side: holds tables, produces rows
  modport slave (
    input  prog_we, prog_sel, prog_tt, out_ready,
    output f, out_idx, out_valid
  );
endinterface

// File: rtl/lut_breadboard.sv
// rtl/lut_breadboard.sv - runtime-programmable truth tables with live and sweep evaluation
module lut_breadboard #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10,
  parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_IN-1:0] i_in_vec,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  lut_breadboard_if.slave bus
);

  localparam int DEPTH = 1 << N_IN;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [DEPTH-1:0] r_tt [N_OUT];
  logic [0:0]       r_state;
  logic [N_OUT-1:0] r_f;
  logic [N_IN-1:0]  r_idx;
  logic             r_valid;
  logic             r_done;

  logic             w_sel_ok;
  logic             w_write;
  logic             w_go;
  logic             w_xfer;
  logic             w_last;
  logic             w_load;
  logic [N_IN-1:0]  w_idx_next;
  logic [N_OUT-1:0] w_f_next;

  // In sweep the presented index doubles as the row counter; the last row
  // is detected by compare, so the counter never needs to wrap.
  assign w_sel_ok = {{(32-SEL_W){1'b0}}, bus.prog_sel} < 32'(N_OUT);
  assign w_write  = (r_state == S_IDLE) && bus.prog_we && w_sel_ok;
  assign w_go     = (r_state == S_IDLE) && i_start && !bus.prog_we;
  assign w_xfer   = (r_state == S_SWEEP) && r_valid && bus.out_ready;
  assign w_last   = (r_idx == {N_IN{1'b1}});
  assign w_load   = (r_state == S_IDLE) || w_xfer;

  // Pick the index whose evaluation is loaded at the next edge
  always_comb begin
    w_idx_next = i_in_vec;
    if (w_go) begin
      w_idx_next = '0;
    end else if (w_xfer && !w_last) begin
      w_idx_next = r_idx + 1'b1;
    end
  end

  // Evaluate all functions at the chosen index from pre-write table contents
  always_comb begin
    w_f_next = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_f_next[k] = r_tt[k][w_idx_next];
    end
  end

  // Truth-table storage; writes only land in IDLE and are frozen during a sweep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_tt[k] <= '0;
      end
    end else if (w_write) begin
      r_tt[bus.prog_sel] <= bus.prog_tt;
    end
  end

  // Mode control, output row registers and the end-of-sweep done pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_f   <= w_f_next;
        r_idx <= w_idx_next;
      end
      if (r_state == S_IDLE) begin
        if (w_go) begin
          r_state <= S_SWEEP;
          r_valid <= 1'b1;
        end
      end else if (w_xfer && w_last) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign bus.f         = r_f;
  assign bus.out_idx   = r_idx;
  assign bus.out_valid = r_valid;
  assign o_busy        = (r_state == S_SWEEP);
  assign o_done        = r_done;

endmodule
